// File: rtl/openram_testchip_ctrl.sv
// Packet register and SRAM pin decode for the OpenRAM test chip: LA parallel load, read-data capture
// and, when GPIO_SCAN_EN is defined, a serial GPIO scan path through the same 112-bit packet.
module openram_testchip_ctrl #(
  parameter int ADDR_SIZE  = 16,
  parameter int DATA_SIZE  = 32,
  parameter int WMASK_SIZE = 4,
  parameter int SEL_SIZE   = 4,
  parameter int MAX_CHIPS  = 16,
  localparam int TOTAL_SIZE = SEL_SIZE + 2 * (ADDR_SIZE + DATA_SIZE + 2 + WMASK_SIZE)
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           in_select,
  input  logic                           la_in_load,
  input  logic                           la_sram_load,
  input  logic [TOTAL_SIZE-1:0]          la_data_in,
  input  logic                           gpio_in,
  input  logic                           gpio_scan,
  input  logic                           gpio_sram_load,
  input  logic [MAX_CHIPS*DATA_SIZE-1:0] sram_data0,
  input  logic [MAX_CHIPS*DATA_SIZE-1:0] sram_data1,
  output logic [ADDR_SIZE-1:0]           left_addr0,
  output logic [ADDR_SIZE-1:0]           left_addr1,
  output logic [DATA_SIZE-1:0]           left_din0,
  output logic [DATA_SIZE-1:0]           left_din1,
  output logic                           left_web0,
  output logic                           left_web1,
  output logic [WMASK_SIZE-1:0]          left_wmask0,
  output logic [WMASK_SIZE-1:0]          left_wmask1,
  output logic [MAX_CHIPS-1:0]           left_csb0,
  output logic [MAX_CHIPS-1:0]           left_csb1,
  output logic [ADDR_SIZE-1:0]           right_addr0,
  output logic [DATA_SIZE-1:0]           right_din0,
  output logic                           right_web0,
  output logic [WMASK_SIZE-1:0]          right_wmask0,
  output logic [MAX_CHIPS-1:0]           right_csb0,
  output logic [TOTAL_SIZE-1:0]          la_data_out,
  output logic                           gpio_out
);

  // Field offsets within the packet; port 1 sits in the low half, port 0 above it, sel on top.
  localparam int PORT_BITS  = ADDR_SIZE + DATA_SIZE + 2 + WMASK_SIZE;
  localparam int WMASK1_LSB = 0;
  localparam int WEB1_BIT   = WMASK_SIZE;
  localparam int CSB1_BIT   = WMASK_SIZE + 1;
  localparam int DIN1_LSB   = WMASK_SIZE + 2;
  localparam int ADDR1_LSB  = DIN1_LSB + DATA_SIZE;
  localparam int WMASK0_LSB = PORT_BITS + WMASK1_LSB;
  localparam int WEB0_BIT   = PORT_BITS + WEB1_BIT;
  localparam int CSB0_BIT   = PORT_BITS + CSB1_BIT;
  localparam int DIN0_LSB   = PORT_BITS + DIN1_LSB;
  localparam int ADDR0_LSB  = PORT_BITS + ADDR1_LSB;
  localparam int SEL_LSB    = 2 * PORT_BITS;

  localparam logic [TOTAL_SIZE-1:0] RESET_PKT =
    (TOTAL_SIZE'(1) << CSB0_BIT) | (TOTAL_SIZE'(1) << WEB0_BIT) |
    (TOTAL_SIZE'(1) << CSB1_BIT) | (TOTAL_SIZE'(1) << WEB1_BIT);

  logic [TOTAL_SIZE-1:0] pkt;
  logic [TOTAL_SIZE-1:0] captured;
  logic [TOTAL_SIZE-1:0] shifted;
  logic [SEL_SIZE-1:0]   sel;
  logic                  do_load;
  logic                  do_scan;
  logic                  do_capture;
  logic [DATA_SIZE-1:0]  dout0 [MAX_CHIPS];
  logic [DATA_SIZE-1:0]  dout1 [MAX_CHIPS];

  assign sel = pkt[SEL_LSB +: SEL_SIZE];

  for (genvar g = 0; g < MAX_CHIPS; g++) begin : g_dout
    assign dout0[g] = sram_data0[g*DATA_SIZE +: DATA_SIZE];
    assign dout1[g] = sram_data1[g*DATA_SIZE +: DATA_SIZE];
  end

`ifdef GPIO_SCAN_EN
  assign do_load    = !in_select && la_in_load;
  assign do_scan    = in_select && gpio_scan;
  assign do_capture = in_select ? (!gpio_scan && gpio_sram_load)
                                : (!la_in_load && la_sram_load);
  assign shifted    = {pkt[TOTAL_SIZE-2:0], gpio_in};
  assign gpio_out   = pkt[TOTAL_SIZE-1];
`else
  logic unused_gpio;
  assign unused_gpio = ^{in_select, gpio_in, gpio_scan, gpio_sram_load};
  assign do_load     = la_in_load;
  assign do_scan     = 1'b0;
  assign do_capture  = !la_in_load && la_sram_load;
  assign shifted     = pkt;
  assign gpio_out    = 1'b0;
`endif

  // Only ports that are selected for a read pick up the macro's dout; everything else is kept.
  always_comb begin
    captured = pkt;
    if (!pkt[CSB0_BIT] && pkt[WEB0_BIT]) captured[DIN0_LSB +: DATA_SIZE] = dout0[sel];
    if (!pkt[CSB1_BIT] && pkt[WEB1_BIT]) captured[DIN1_LSB +: DATA_SIZE] = dout1[sel];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)           pkt <= RESET_PKT;
    else if (do_load)    pkt <= la_data_in;
    else if (do_scan)    pkt <= shifted;
    else if (do_capture) pkt <= captured;
  end

  assign left_addr0   = pkt[ADDR0_LSB +: ADDR_SIZE];
  assign left_din0    = pkt[DIN0_LSB +: DATA_SIZE];
  assign left_web0    = pkt[WEB0_BIT];
  assign left_wmask0  = pkt[WMASK0_LSB +: WMASK_SIZE];
  assign left_addr1   = pkt[ADDR1_LSB +: ADDR_SIZE];
  assign left_din1    = pkt[DIN1_LSB +: DATA_SIZE];
  assign left_web1    = pkt[WEB1_BIT];
  assign left_wmask1  = pkt[WMASK1_LSB +: WMASK_SIZE];
  assign right_addr0  = left_addr0;
  assign right_din0   = left_din0;
  assign right_web0   = left_web0;
  assign right_wmask0 = left_wmask0;
  assign la_data_out  = pkt;

  // Lower half of the chip index space is the dual-port left bank, upper half the single-port right bank.
  always_comb begin
    left_csb0  = '1;
    left_csb1  = '1;
    right_csb0 = '1;
    for (int i = 0; i < MAX_CHIPS; i++) begin
      if (sel == SEL_SIZE'(i)) begin
        if (i < MAX_CHIPS / 2) begin
          left_csb0[i] = pkt[CSB0_BIT];
          left_csb1[i] = pkt[CSB1_BIT];
        end else begin
          right_csb0[i] = pkt[CSB0_BIT];
        end
      end
    end
  end

endmodule

// File: tb/tb_openram_testchip_ctrl.sv
// Bench for openram_testchip_ctrl: behavioural SRAM macros, a field-level packet model with a
// reference memory, and a scoreboard monitor comparing every observable output.
module tb_openram_testchip_ctrl;

  localparam int W = 320;

  typedef struct packed {
    logic [3:0]  sel;
    logic [15:0] addr0;
    logic [31:0] din0;
    logic        csb0;
    logic        web0;
    logic [3:0]  wmask0;
    logic [15:0] addr1;
    logic [31:0] din1;
    logic        csb1;
    logic        web1;
    logic [3:0]  wmask1;
  } pkt_t;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         in_select = 1'b0;
  logic         la_in_load = 1'b0;
  logic         la_sram_load = 1'b0;
  logic [111:0] la_data_in = '0;
  logic         gpio_in = 1'b0;
  logic         gpio_scan = 1'b0;
  logic         gpio_sram_load = 1'b0;
  logic [511:0] sram_data0;
  logic [511:0] sram_data1;
  logic [15:0]  left_addr0, left_addr1, right_addr0;
  logic [31:0]  left_din0, left_din1, right_din0;
  logic         left_web0, left_web1, right_web0;
  logic [3:0]   left_wmask0, left_wmask1, right_wmask0;
  logic [15:0]  left_csb0, left_csb1, right_csb0;
  logic [111:0] la_data_out;
  logic         gpio_out;

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  openram_testchip_ctrl dut (
    .clk(clk), .reset(reset), .in_select(in_select), .la_in_load(la_in_load),
    .la_sram_load(la_sram_load), .la_data_in(la_data_in), .gpio_in(gpio_in),
    .gpio_scan(gpio_scan), .gpio_sram_load(gpio_sram_load),
    .sram_data0(sram_data0), .sram_data1(sram_data1),
    .left_addr0(left_addr0), .left_addr1(left_addr1), .left_din0(left_din0),
    .left_din1(left_din1), .left_web0(left_web0), .left_web1(left_web1),
    .left_wmask0(left_wmask0), .left_wmask1(left_wmask1),
    .left_csb0(left_csb0), .left_csb1(left_csb1),
    .right_addr0(right_addr0), .right_din0(right_din0), .right_web0(right_web0),
    .right_wmask0(right_wmask0), .right_csb0(right_csb0),
    .la_data_out(la_data_out), .gpio_out(gpio_out)
  );

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] m);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (m[b]) r[b*8 +: 8] = d[b*8 +: 8];
    return r;
  endfunction

  // ---------------- behavioural SRAM macros (registered dout) ----------------
  logic [15:0][31:0] dout0_p = '0;
  logic [15:0][31:0] dout1_p = '0;
  logic [31:0] sram_mem [int];
  assign sram_data0 = dout0_p;
  assign sram_data1 = dout1_p;

  function automatic logic [31:0] mem_rd(input int key);
    return sram_mem.exists(key) ? sram_mem[key] : 32'h0;
  endfunction

  initial forever begin
    @(posedge clk);
    for (int c = 0; c < 16; c++) begin
      if (c < 8) begin
        if (!left_csb0[c]) begin
          if (!left_web0) sram_mem[c*65536 + int'(left_addr0)] =
                            merge(mem_rd(c*65536 + int'(left_addr0)), left_din0, left_wmask0);
          else dout0_p[c] <= mem_rd(c*65536 + int'(left_addr0));
        end
        if (!left_csb1[c]) begin
          if (!left_web1) sram_mem[c*65536 + int'(left_addr1)] =
                            merge(mem_rd(c*65536 + int'(left_addr1)), left_din1, left_wmask1);
          else dout1_p[c] <= mem_rd(c*65536 + int'(left_addr1));
        end
      end else if (!right_csb0[c]) begin
        if (!right_web0) sram_mem[c*65536 + int'(right_addr0)] =
                           merge(mem_rd(c*65536 + int'(right_addr0)), right_din0, right_wmask0);
        else dout0_p[c] <= mem_rd(c*65536 + int'(right_addr0));
      end
    end
  end

  // ---------------- reference model ----------------
  pkt_t model;
  logic [31:0] ref_mem [int];

  function automatic logic [31:0] ref_rd(input logic [3:0] s, input logic [15:0] a);
    int key;
    key = int'(s) * 65536 + int'(a);
    return ref_mem.exists(key) ? ref_mem[key] : 32'h0;
  endfunction

  // Memory effect of a packet being presented to the macros (port 1 reaches only left chips).
  function automatic void ref_write(input pkt_t p);
    if (!p.csb0 && !p.web0)
      ref_mem[int'(p.sel)*65536 + int'(p.addr0)] = merge(ref_rd(p.sel, p.addr0), p.din0, p.wmask0);
    if (!p.csb1 && !p.web1 && p.sel < 4'd8)
      ref_mem[int'(p.sel)*65536 + int'(p.addr1)] = merge(ref_rd(p.sel, p.addr1), p.din1, p.wmask1);
  endfunction

  function automatic pkt_t model_capture(input pkt_t p);
    pkt_t r;
    r = p;
    if (!p.csb0 && p.web0) r.din0 = ref_rd(p.sel, p.addr0);
    if (!p.csb1 && p.web1) r.din1 = (p.sel < 4'd8) ? ref_rd(p.sel, p.addr1) : 32'h0;
    return r;
  endfunction

  function automatic pkt_t rst_pkt();
    pkt_t p;
    p = '0;
    p.csb0 = 1'b1; p.web0 = 1'b1; p.csb1 = 1'b1; p.web1 = 1'b1;
    return p;
  endfunction

  function automatic logic [W-1:0] exp_vec(input pkt_t p);
    logic [15:0] l0, l1, r0;
    logic g;
    l0 = '1; l1 = '1; r0 = '1;
    for (int i = 0; i < 16; i++) begin
      if (int'(p.sel) == i) begin
        if (i < 8) begin
          if (!p.csb0) l0[i] = 1'b0;
          if (!p.csb1) l1[i] = 1'b0;
        end else if (!p.csb0) r0[i] = 1'b0;
      end
    end
`ifdef GPIO_SCAN_EN
    g = p.sel[3];
`else
    g = 1'b0;
`endif
    return {p, l0, l1, r0, g,
            p.addr0, p.din0, p.web0, p.wmask0,
            p.addr1, p.din1, p.web1, p.wmask1,
            p.addr0, p.din0, p.web0, p.wmask0};
  endfunction

  function automatic pkt_t mk(input logic [3:0] s, input logic [15:0] a0, input logic [31:0] d0,
                              input logic c0, input logic w0, input logic [3:0] m0,
                              input logic [15:0] a1, input logic [31:0] d1,
                              input logic c1, input logic w1, input logic [3:0] m1);
    return '{s, a0, d0, c0, w0, m0, a1, d1, c1, w1, m1};
  endfunction

  function automatic pkt_t rand_raw();
    logic [127:0] r;
    r = {$urandom(), $urandom(), $urandom(), $urandom()};
    return pkt_t'(r[111:0]);
  endfunction

  function automatic pkt_t gen_pkt(input int kind);
    pkt_t p;
    p = rand_raw();
    p.addr0 = 16'($urandom_range(0, 7));
    p.addr1 = 16'($urandom_range(0, 7));
    case (kind)
      0: begin p.csb0 = 0; p.web0 = 0; p.csb1 = 1; end
      1: begin p.csb0 = 0; p.web0 = 1; p.csb1 = 1; end
      2: begin p.csb0 = 0; p.web0 = 1; p.csb1 = 0; p.web1 = 1; end
      3: begin p.csb0 = 1; p.csb1 = 0; p.web1 = 0; end
      default: begin p.csb0 = 1; p.csb1 = 1; end
    endcase
    return p;
  endfunction

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  string        tag_q[$];
  event         chk_ev;
  int           n_vec = 0;
  int           n_err = 0;
  logic [W-1:0] act_vec;
  logic         sel_mode;

  assign act_vec = {la_data_out, left_csb0, left_csb1, right_csb0, gpio_out,
                    left_addr0, left_din0, left_web0, left_wmask0,
                    left_addr1, left_din1, left_web1, left_wmask1,
                    right_addr0, right_din0, right_web0, right_wmask0};

  task automatic expect_now(input string tag, input pkt_t p);
    exp_q.push_back(exp_vec(p));
    tag_q.push_back(tag);
    -> chk_ev;
  endtask

  initial begin : monitor
    logic [W-1:0] e;
    string t;
    forever begin
      @(chk_ev);
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        n_vec++;
        if (act_vec !== e) begin
          n_err++;
          $display("FAIL %s: got %h want %h", t, act_vec, e);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "bench timeout");
  end

  // ---------------- drivers ----------------
  task automatic la_load(input pkt_t p);
    @(negedge clk);
`ifdef GPIO_SCAN_EN
    sel_mode = 1'b0;
`else
    sel_mode = 1'($urandom_range(0, 1));
`endif
    in_select = sel_mode;
    la_data_in = p;
    la_in_load = 1'b1;
    la_sram_load = 1'($urandom_range(0, 1));
    gpio_scan = 1'($urandom_range(0, 1));
    gpio_sram_load = 1'($urandom_range(0, 1));
    gpio_in = 1'($urandom_range(0, 1));
    @(negedge clk);
    la_in_load = 1'b0; la_sram_load = 1'b0; gpio_scan = 1'b0; gpio_sram_load = 1'b0;
    model = p;
    ref_write(p);
    expect_now("la_load", model);
  endtask

  task automatic la_capture();
    @(negedge clk);
    in_select = 1'b0;
    la_sram_load = 1'b1;
    gpio_scan = 1'($urandom_range(0, 1));
    repeat (2) @(negedge clk);
    la_sram_load = 1'b0; gpio_scan = 1'b0;
    model = model_capture(model);
    expect_now("la_capture", model);
  endtask

  task automatic idle_hold();
    @(negedge clk);
    in_select = 1'b0;
    la_data_in = rand_raw();
    gpio_scan = 1'($urandom_range(0, 1));
    repeat (2) @(negedge clk);
    gpio_scan = 1'b0;
    expect_now("idle_hold", model);
  endtask

  task automatic async_reset();
    repeat (2) @(negedge clk);
    #2 reset = 1'b1;
    #1 expect_now("async_reset", rst_pkt());
    #1 reset = 1'b0;
    model = rst_pkt();
  endtask

`ifdef GPIO_SCAN_EN
  task automatic scan_bit(input logic b);
    @(negedge clk);
    in_select = 1'b1;
    gpio_in = b;
    gpio_scan = 1'b1;
    la_in_load = 1'($urandom_range(0, 1));
    la_data_in = rand_raw();
    la_sram_load = 1'($urandom_range(0, 1));
    gpio_sram_load = 1'($urandom_range(0, 1));
    @(negedge clk);
    gpio_scan = 1'b0; la_in_load = 1'b0; la_sram_load = 1'b0; gpio_sram_load = 1'b0;
    model = pkt_t'({model[110:0], b});
    ref_write(model);
    expect_now("gpio_scan", model);
  endtask

  task automatic gpio_capture();
    @(negedge clk);
    in_select = 1'b1;
    gpio_sram_load = 1'b1;
    la_in_load = 1'($urandom_range(0, 1));
    la_data_in = rand_raw();
    repeat (2) @(negedge clk);
    gpio_sram_load = 1'b0; la_in_load = 1'b0;
    model = model_capture(model);
    expect_now("gpio_capture", model);
  endtask
`endif

  // ---------------- main sequence ----------------
  initial begin : main
    pkt_t p;
    @(negedge clk);
    expect_now("reset_state", rst_pkt());
    model = rst_pkt();
    #1 reset = 1'b0;

    la_load(mk(4'd0, 16'd1, 32'd1, 1'b0, 1'b0, 4'hF, 16'd0, 32'd0, 1'b1, 1'b1, 4'h0));
    la_capture();
    la_load(mk(4'd0, 16'd2, 32'd2, 1'b0, 1'b0, 4'hF, 16'd0, 32'd0, 1'b1, 1'b1, 4'h0));
    la_capture();
    la_load(mk(4'd0, 16'd1, 32'd0, 1'b0, 1'b1, 4'h0, 16'd2, 32'd0, 1'b0, 1'b1, 4'h0));
    la_capture();
    la_load(mk(4'd9, 16'd3, 32'hA5A5_5A5A, 1'b0, 1'b0, 4'hF, 16'd0, 32'd0, 1'b1, 1'b1, 4'h0));
    la_capture();
    la_load(mk(4'd9, 16'd3, 32'h0, 1'b0, 1'b1, 4'hF, 16'd0, 32'd0, 1'b1, 1'b1, 4'h0));
    la_capture();
    idle_hold();

    repeat (40) begin
      la_load(gen_pkt(int'($urandom_range(0, 4))));
      la_capture();
      if ($urandom_range(0, 3) == 0) idle_hold();
    end

`ifdef GPIO_SCAN_EN
    p = gen_pkt(2);
    for (int i = 111; i >= 0; i--) scan_bit(p[i]);
    gpio_capture();
    p = rand_raw();
    for (int i = 111; i >= 72; i--) scan_bit(p[i]);
    async_reset();
`else
    la_load(gen_pkt(0));
    async_reset();
`endif

    repeat (10) begin
      la_load(gen_pkt(int'($urandom_range(0, 4))));
      la_capture();
    end

    repeat (2) @(negedge clk);
    for (int k = 0; k < 100 && exp_q.size() != 0; k++) #1;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: got %0d pending want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
